// File: rtl/pr_pkg.sv
// Shared types and default sizes for the physical register file.
// Imported by pr_file_mp, pr_bypass_mux and the bench.
package pr_pkg;

   localparam int NUM_PR_DEF    = 64;
   localparam int XLEN_DEF      = 64;
   localparam int NUM_WR_DEF    = 2;
   localparam int NUM_RD_DEF    = 4;
   localparam int NUM_ALLOC_DEF = 2;
   localparam int PR_IDX_W      = $clog2(NUM_PR_DEF);
   localparam int ZERO_PR_DEF   = NUM_PR_DEF - 1;

   typedef logic [PR_IDX_W-1:0] pr_idx_t;

   typedef struct packed {
      logic                en;
      pr_idx_t             idx;
      logic [XLEN_DEF-1:0] data;
   } pr_wr_port_t;

   typedef struct packed {
      pr_idx_t idx;
   } pr_rd_req_t;

   typedef struct packed {
      logic [XLEN_DEF-1:0] data;
      logic                ready;
   } pr_rd_rsp_t;

   typedef pr_wr_port_t [NUM_WR_DEF-1:0] pr_wr_ports_t;
   typedef pr_rd_req_t  [NUM_RD_DEF-1:0] pr_rd_reqs_t;
   typedef pr_rd_rsp_t  [NUM_RD_DEF-1:0] pr_rd_rsps_t;

endpackage

// File: rtl/pr_bypass_mux.sv
// One read port: zero reg, lowest matching write-back, else array value.
// Ports: i_rd_idx/i_rd_ok request, i_wr_* live write-backs, i_arr_* stored value, o_* result.
module pr_bypass_mux
   import pr_pkg::*;
#(
   parameter int NUM_WR  = NUM_WR_DEF,
   parameter int XLEN    = XLEN_DEF,
   parameter int IW      = PR_IDX_W,
   parameter int ZERO_PR = ZERO_PR_DEF
) (
   input  logic [IW-1:0]          i_rd_idx,
   input  logic                   i_rd_ok,
   input  logic [NUM_WR-1:0]      i_wr_vld,
   input  logic [NUM_WR*IW-1:0]   i_wr_idx,
   input  logic [NUM_WR*XLEN-1:0] i_wr_data,
   input  logic [XLEN-1:0]        i_arr_data,
   input  logic                   i_arr_ready,
   output logic [XLEN-1:0]        o_data,
   output logic                   o_ready
);

   localparam logic [IW-1:0] ZIDX = IW'(ZERO_PR);

   always_comb begin
      o_data  = '0;
      o_ready = 1'b0;
      if (!i_rd_ok) begin
         o_data  = '0;
         o_ready = 1'b0;
      end else if (i_rd_idx == ZIDX) begin
         o_ready = 1'b1;
      end else begin
         o_data  = i_arr_data;
         o_ready = i_arr_ready;
         // descending scan so the lowest port is applied last and wins
         for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (i_wr_vld[p] && i_wr_idx[p*IW +: IW] == i_rd_idx) begin
               o_data  = i_wr_data[p*XLEN +: XLEN];
               o_ready = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pr_file_mp.sv
// Multi-port physical register file with per-register ready scoreboard.
// Ports: clock/reset/en, wr_* CDB write-backs, alloc_* dispatch, rd_* operands, wr_conflict, pr_data.
module pr_file_mp
   import pr_pkg::*;
#(
   parameter int NUM_PR    = NUM_PR_DEF,
   parameter int XLEN      = XLEN_DEF,
   parameter int NUM_WR    = NUM_WR_DEF,
   parameter int NUM_RD    = NUM_RD_DEF,
   parameter int NUM_ALLOC = NUM_ALLOC_DEF,
   parameter int ZERO_PR   = NUM_PR - 1,
   parameter int RD_LAT    = 0,
   localparam int IW       = $clog2(NUM_PR)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      en,
   input  logic [NUM_WR-1:0]         wr_en,
   input  logic [NUM_WR*IW-1:0]      wr_idx,
   input  logic [NUM_WR*XLEN-1:0]    wr_data,
   input  logic [NUM_ALLOC-1:0]      alloc_en,
   input  logic [NUM_ALLOC*IW-1:0]   alloc_idx,
   input  logic [NUM_RD*IW-1:0]      rd_idx,
   output logic [NUM_RD*XLEN-1:0]    rd_data,
   output logic [NUM_RD-1:0]         rd_ready,
   output logic                      wr_conflict
`ifndef SYNTH_TEST
   ,output logic [NUM_PR*XLEN-1:0]   pr_data
`endif
);

   localparam bit            POW2 = (NUM_PR == (1 << IW));
   localparam logic [IW-1:0] ZIDX = IW'(ZERO_PR);

   logic [XLEN-1:0]        r_pr [NUM_PR];
   logic [NUM_PR-1:0]      r_ready;
   logic                   r_conflict;

   logic [IW-1:0]          w_wr_idx [NUM_WR];
   logic [IW-1:0]          w_al_idx [NUM_ALLOC];
   logic [IW-1:0]          w_rd_idx [NUM_RD];
   logic [NUM_WR-1:0]      w_wr_ok;
   logic [NUM_ALLOC-1:0]   w_al_ok;
   logic [NUM_RD-1:0]      w_rd_ok;
   logic [NUM_WR-1:0]      w_wr_vld;
   logic [NUM_ALLOC-1:0]   w_al_vld;
   logic                   w_conflict;
   logic [NUM_RD*XLEN-1:0] w_byp_data;
   logic [NUM_RD-1:0]      w_byp_rdy;

   for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
      assign w_wr_idx[p] = wr_idx[p*IW +: IW];
      assign w_wr_vld[p] = en & wr_en[p] & w_wr_ok[p]
                         & (w_wr_idx[p] != ZIDX);
   end

   for (genvar a = 0; a < NUM_ALLOC; a++) begin : g_al
      assign w_al_idx[a] = alloc_idx[a*IW +: IW];
      assign w_al_vld[a] = alloc_en[a] & w_al_ok[a]
                         & (w_al_idx[a] != ZIDX);
   end

   // range checks only exist when the index space has holes
   if (POW2) begin : g_pow2
      assign w_wr_ok = '1;
      assign w_al_ok = '1;
      assign w_rd_ok = '1;
   end else begin : g_rng
      localparam logic [IW:0] LIM = (IW+1)'(NUM_PR);
      for (genvar p = 0; p < NUM_WR; p++) begin : g_w
         assign w_wr_ok[p] = {1'b0, w_wr_idx[p]} < LIM;
      end
      for (genvar a = 0; a < NUM_ALLOC; a++) begin : g_a
         assign w_al_ok[a] = {1'b0, w_al_idx[a]} < LIM;
      end
      for (genvar r = 0; r < NUM_RD; r++) begin : g_r
         assign w_rd_ok[r] = {1'b0, w_rd_idx[r]} < LIM;
      end
   end

   always_comb begin
      w_conflict = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (w_wr_vld[p] && w_wr_vld[q]
                && w_wr_idx[p] == w_wr_idx[q])
               w_conflict = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PR; i++) r_pr[i] <= '0;
         r_ready    <= '1;
         r_conflict <= 1'b0;
      end else if (en) begin
         // lowest port assigned last so its data lands
         for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (w_wr_vld[p]) begin
               r_pr[w_wr_idx[p]]    <= wr_data[p*XLEN +: XLEN];
               r_ready[w_wr_idx[p]] <= 1'b1;
            end
         end
         // alloc after write-back: a same-cycle pair leaves ready low
         for (int a = 0; a < NUM_ALLOC; a++) begin
            if (w_al_vld[a]) r_ready[w_al_idx[a]] <= 1'b0;
         end
         if (w_conflict) r_conflict <= 1'b1;
      end
   end

   assign wr_conflict = r_conflict;

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      assign w_rd_idx[r] = rd_idx[r*IW +: IW];
      pr_bypass_mux #(
         .NUM_WR  (NUM_WR),
         .XLEN    (XLEN),
         .IW      (IW),
         .ZERO_PR (ZERO_PR)
      ) u_mux (
         .i_rd_idx    (w_rd_idx[r]),
         .i_rd_ok     (w_rd_ok[r]),
         .i_wr_vld    (w_wr_vld),
         .i_wr_idx    (wr_idx),
         .i_wr_data   (wr_data),
         .i_arr_data  (r_pr[w_rd_idx[r]]),
         .i_arr_ready (r_ready[w_rd_idx[r]]),
         .o_data      (w_byp_data[r*XLEN +: XLEN]),
         .o_ready     (w_byp_rdy[r])
      );
   end

   if (RD_LAT == 0) begin : g_comb
      assign rd_data  = w_byp_data;
      assign rd_ready = w_byp_rdy;
   end else begin : g_reg
      logic [NUM_RD*XLEN-1:0] r_rd_data;
      logic [NUM_RD-1:0]      r_rd_ready;
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            r_rd_data  <= '0;
            r_rd_ready <= '1;
         end else if (en) begin
            r_rd_data  <= w_byp_data;
            r_rd_ready <= w_byp_rdy;
         end
      end
      assign rd_data  = r_rd_data;
      assign rd_ready = r_rd_ready;
   end

`ifndef SYNTH_TEST
   for (genvar i = 0; i < NUM_PR; i++) begin : g_dbg
      assign pr_data[i*XLEN +: XLEN] = r_pr[i];
   end
`endif

endmodule

// File: tb/tb_pr_file_mp.sv
// Directed bench for pr_file_mp: combinational and registered-read instances.
// Ports: none; drives both DUTs from shared stimulus.
module tb_pr_file_mp;
   import pr_pkg::*;

   logic           clock = 1'b0;
   logic           reset;
   logic           en;
   logic [1:0]     wr_en;
   logic [11:0]    wr_idx;
   logic [127:0]   wr_data;
   logic [1:0]     alloc_en;
   logic [11:0]    alloc_idx;
   logic [23:0]    rd_idx;
   logic [255:0]   rd_data0, rd_data1;
   logic [3:0]     rd_ready0, rd_ready1;
   logic           conf0, conf1;
   logic [4095:0]  pr0, pr1;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clock = ~clock;

   pr_file_mp #(.RD_LAT(0)) u0 (
      .clock(clock), .reset(reset), .en(en),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_idx(alloc_idx),
      .rd_idx(rd_idx), .rd_data(rd_data0), .rd_ready(rd_ready0),
      .wr_conflict(conf0), .pr_data(pr0)
   );

   pr_file_mp #(.RD_LAT(1)) u1 (
      .clock(clock), .reset(reset), .en(en),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_idx(alloc_idx),
      .rd_idx(rd_idx), .rd_data(rd_data1), .rd_ready(rd_ready1),
      .wr_conflict(conf1), .pr_data(pr1)
   );

   typedef struct {
      logic        en;
      logic [1:0]  we;
      pr_idx_t     wi0;
      logic [63:0] wd0;
      pr_idx_t     wi1;
      logic [63:0] wd1;
      logic [1:0]  ae;
      pr_idx_t     ai0;
      pr_idx_t     ai1;
      pr_idx_t     ri;
      logic [63:0] xd;
      logic        xr;
   } vec_t;

   vec_t tv [17];

   function automatic vec_t mk(
      input logic en_i, input logic [1:0] we,
      input int wi0, input logic [63:0] wd0,
      input int wi1, input logic [63:0] wd1,
      input logic [1:0] ae, input int ai0, input int ai1,
      input int ri, input logic [63:0] xd, input logic xr);
      vec_t v;
      v.en = en_i; v.we = we;
      v.wi0 = pr_idx_t'(wi0); v.wd0 = wd0;
      v.wi1 = pr_idx_t'(wi1); v.wd1 = wd1;
      v.ae = ae; v.ai0 = pr_idx_t'(ai0); v.ai1 = pr_idx_t'(ai1);
      v.ri = pr_idx_t'(ri); v.xd = xd; v.xr = xr;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      tot_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h want %h", nm, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic idle();
      en = 1'b1; wr_en = '0; alloc_en = '0;
      wr_idx = '0; wr_data = '0; alloc_idx = '0;
   endtask

   function automatic logic [63:0] prs(input logic [4095:0] v, input int i);
      return v[i*64 +: 64];
   endfunction

   initial begin
      reset = 1'b0;
      idle();
      rd_idx = '0;

      tv[0]  = mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 5, 0, 5, 64'h0, 1);
      tv[1]  = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 5, 64'h0, 0);
      tv[2]  = mk(1, 2'b10, 0, 0, 5, 64'hDEAD, 2'b00, 0, 0, 5, 64'hDEAD, 1);
      tv[3]  = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 5, 64'hDEAD, 1);
      tv[4]  = mk(1, 2'b11, 7, 64'h11, 7, 64'h22, 2'b00, 0, 0, 7, 64'h11, 1);
      tv[5]  = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 7, 64'h11, 1);
      tv[6]  = mk(1, 2'b01, 63, 64'hFFFF, 0, 0, 2'b01, 63, 0, 63, 64'h0, 1);
      tv[7]  = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 63, 64'h0, 1);
      tv[8]  = mk(1, 2'b01, 10, 64'h1010, 0, 0, 2'b01, 10, 0, 10, 64'h1010, 1);
      tv[9]  = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10, 64'h1010, 0);
      tv[10] = mk(1, 2'b10, 0, 0, 12, 64'hAB, 2'b00, 0, 0, 12, 64'hAB, 1);
      tv[11] = mk(0, 2'b01, 3, 64'h55, 0, 0, 2'b00, 0, 0, 3, 64'h0, 1);
      tv[12] = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 3, 64'h0, 1);
      tv[13] = mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 0, 12, 12, 64'hAB, 1);
      tv[14] = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 12, 64'hAB, 0);
      tv[15] = mk(1, 2'b11, 12, 64'hC0, 14, 64'hE0, 2'b00, 0, 0, 14, 64'hE0, 1);
      tv[16] = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 12, 64'hC0, 1);

      repeat (2) @(negedge clock);
      chk("rst_u1_data", rd_data1[63:0], 64'h0);
      chk("rst_u1_ready", {60'h0, rd_ready1}, 64'hF);
      reset = 1'b1;
      @(negedge clock);

      // reset state: every index reads zero and ready on all ports
      for (int i = 0; i < 64; i++) begin
         rd_idx = {4{6'(i)}};
         #1;
         tot_cnt++;
         if (rd_data0 !== '0 || rd_ready0 !== 4'hF)
            $display("FAIL rst_read[%0d]: got ready %b data0 %h want 1111/0",
                     i, rd_ready0, rd_data0[63:0]);
         else
            pass_cnt++;
      end
      chk("rst_pr_zero", {63'h0, pr0 == '0}, 64'h1);
      chk("rst_conflict", {63'h0, conf0}, 64'h0);

      for (int i = 0; i < 17; i++) begin
         @(posedge clock);
         #1;
         en        = tv[i].en;
         wr_en     = tv[i].we;
         wr_idx    = {tv[i].wi1, tv[i].wi0};
         wr_data   = {tv[i].wd1, tv[i].wd0};
         alloc_en  = tv[i].ae;
         alloc_idx = {tv[i].ai1, tv[i].ai0};
         rd_idx    = {4{tv[i].ri}};
         @(negedge clock);
         if (i == 4) chk("conflict_pre", {63'h0, conf0}, 64'h0);
         for (int r = 0; r < 4; r++) begin
            chk($sformatf("v%0d_p%0d_data", i, r),
                rd_data0[r*64 +: 64], tv[i].xd);
            chk($sformatf("v%0d_p%0d_ready", i, r),
                {63'h0, rd_ready0[r]}, {63'h0, tv[i].xr});
         end
      end
      @(posedge clock);
      #1;
      idle();

      chk("pr7_low_port", prs(pr0, 7), 64'h11);
      chk("pr63_zero", prs(pr0, 63), 64'h0);
      chk("pr3_en_hold", prs(pr0, 3), 64'h0);
      chk("pr12_low_port", prs(pr0, 12), 64'hC0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         chk($sformatf("conflict_sticky_%0d", c), {63'h0, conf0}, 64'h1);
      end

      // registered read holds while stalled
      @(posedge clock);
      #1;
      wr_en = 2'b01; wr_idx = {6'd0, 6'd3}; wr_data = {64'h0, 64'h33};
      rd_idx = {4{6'd3}};
      @(posedge clock);
      #1;
      chk("lat1_wr3_data", rd_data1[63:0], 64'h33);
      chk("lat1_wr3_ready", {63'h0, rd_ready1[0]}, 64'h1);
      en = 1'b0; wr_data = {64'h0, 64'h55}; rd_idx = {4{6'd4}};
      @(posedge clock);
      #1;
      chk("lat1_stall_hold", rd_data1[63:0], 64'h33);
      chk("stall_pr3", prs(pr0, 3), 64'h33);

      // one-cycle registered latency
      en = 1'b1; wr_idx = {6'd0, 6'd9}; wr_data = {64'h0, 64'h99};
      rd_idx = {4{6'd9}};
      @(negedge clock);
      chk("lat1_before_edge", rd_data1[63:0], 64'h33);
      @(posedge clock);
      #1;
      chk("lat1_after_edge", rd_data1[63:0], 64'h99);
      chk("lat1_after_ready", {63'h0, rd_ready1[0]}, 64'h1);

      // reset in the middle of a write burst
      wr_idx = {6'd0, 6'd20}; wr_data = {64'h0, 64'h2020};
      rd_idx = {4{6'd20}};
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_u1_data", {63'h0, rd_data1 == '0}, 64'h1);
      chk("midrst_u1_ready", {60'h0, rd_ready1}, 64'hF);
      chk("midrst_conflict", {62'h0, conf0, conf1}, 64'h0);
      chk("midrst_pr_clear", {63'h0, pr1 == '0}, 64'h1);
      idle();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("midrst_pr20", prs(pr0, 20), 64'h0);
      chk("midrst_pr9", prs(pr0, 9), 64'h0);
      chk("midrst_u1_rd20", rd_data1[63:0], 64'h0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
